lsu_mem_ctrl: RTL
=================

Name: lsu_mem_ctrl

Overview:
Load/store initiator that drives the word-wide synchronous data RAM on behalf of the RV32I core. It accepts one load or store request per transaction via a valid/ready handshake and converts byte addresses to word addresses. Sub-word stores become 4-bit byte strobes with lane-replicated data. Sub-word load data is extracted and sign/zero-extended, and the result is returned through a registered response handshake.

Parameters:
ADDR_W, 16, RAM word-address width; the request byte address is ADDR_W+2 bits.

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  controller can accept; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I width/sign code
req_addr  in  ADDR_W+2  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  response/result available
resp_ready  in  1  core consumes response
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  illegal funct3 (or misaligned, see macro)
mem_addr  out  ADDR_W  RAM word address = req_addr[ADDR_W+1:2]
mem_read  out  1  RAM read enable
mem_write  out  4  RAM byte strobes, bit i = byte lane i
mem_wdata  out  32  RAM write data
mem_rdata  in  32  RAM registered read data, valid the cycle after mem_read

Behaviour:
- Reset values: req_ready=0 during reset, then 1 in IDLE. resp_valid=0, resp_rdata=0, resp_err=0, mem_read=0, mem_write=0.
- States: IDLE, RD_DATA, RESP.
- Accept: in IDLE, req_valid=1 accepts the request in cycle T. mem_addr, mem_read, mem_write and mem_wdata are combinational from the request in T only, and are 0 in every other cycle. The byte offset addr[1:0] and funct3 are latched at T.
- Loads (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU):
  - mem_read=1 in T; next state RD_DATA.
  - At T+1, mem_rdata is sampled. The selected byte or half is extracted and extended, then registered into resp_rdata.
  - Next state RESP; resp_valid=1 from T+2.
- Stores (000 SB, 001 SH, 010 SW):
  - SB: mem_write = 4'b0001 << addr[1:0]; mem_wdata = byte replicated to all four lanes.
  - SH: mem_write = 4'b0011 << {addr[1],1'b0}; mem_wdata = half replicated to both halves.
  - SW: mem_write = 4'b1111.
  - Next state RESP; resp_valid=1 from T+1 with resp_rdata=0.
- Illegal funct3 (loads 011/110/111; stores 011 and above): no mem_read or mem_write. Next state RESP with resp_err=1 and resp_rdata=0.
- RESP: resp_valid, resp_rdata and resp_err are held stable until resp_ready=1, then state goes to IDLE.
  - A new request is not accepted in the same cycle as the handshake; the earliest new accept is the next cycle.
  - Throughput: at most one transaction every 2 cycles for stores and 3 for loads.
- Misalignment (macro off): the offending low address bits are ignored.
  - LH/LHU/SH use addr[1] only.
  - LW/SW use word alignment.
- Reset mid-transaction: state goes to IDLE and any pending response is dropped. No memory strobe is issued in the reset cycle, even if req_valid=1.
- req_* inputs are ignored outside IDLE.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, issue no mem_read or mem_write. The controller goes to RESP with resp_err=1 and resp_rdata=0, at T+1.
- Undefined: aligned-down behaviour as above; resp_err reports illegal funct3 only.

Test Plan:
- Reset with req_valid=1: all outputs 0 and no mem_write strobe in the reset cycle; req_ready=1 the cycle after rst deasserts.
- SW addr 0x0010, data 0xDEADBEEF -> mem_addr=0x0004, mem_write=4'b1111 in T; resp_valid at T+1. Then LW 0x0010 -> mem_read in T, resp_rdata=0xDEADBEEF at T+2.
- SB addr 0x0013, data 0x000000A5 -> mem_write=4'b1000, mem_wdata=0xA5A5A5A5. With the RAM word now 0xA5ADBEEF:
  - LB 0x0013 -> 0xFFFFFFA5.
  - LBU 0x0013 -> 0x000000A5.
- LH 0x0012 on word 0x8001BEEF -> 0xFFFF8001; LHU -> 0x00008001. SH 0x0012, data 0x1234 -> mem_write=4'b1100, mem_wdata=0x12341234.
- Backpressure: hold resp_ready=0 for 5 cycles after a load -> resp_valid and resp_rdata stable and req_ready=0 throughout. After the handshake, a new request is accepted in the next cycle.
- Load funct3=3'b011 -> no mem_read, resp_err=1, resp_rdata=0. With MISALIGN_TRAP_EN, LW 0x0011 -> no mem access, resp_err=1 at T+1.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: RV32I load/store initiator for a word-wide synchronous data RAM.
// Latency: store/error response valid 1 cycle after accept, load response 2 cycles after accept.
// Backpressure: response held stable until resp_ready_i; req_ready_o only high in IDLE (no overlap).
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_*_i / req_ready_o   request channel (byte address, funct3, store data)
//   resp_*_o / resp_ready_i registered response channel (extended load data, error flag)
//   mem_*_o / mem_rdata_i   RAM interface (word address, read enable, byte strobes, data)
//
// Optional build macro: MISALIGN_TRAP_EN -- when defined, misaligned halfword/word accesses
// are rejected with resp_err_o instead of being aligned down.
module lsu_mem_ctrl #(
    parameter int ADDR_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W+1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_read_o,
    output logic [3:0]        mem_write_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_DATA = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t      state_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic        accept;
    logic        req_legal;
    logic        req_misalign;
    logic        req_ok;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext_d;

    // Reset gates acceptance so no strobe can leak out during the reset cycle.
    assign accept      = (state_q == IDLE) && req_valid_i && !rst_i;
    assign req_ready_o = (state_q == IDLE) && !rst_i;

    // Request decode: legality, alignment and store lane formatting.
    always_comb begin
        req_legal    = 1'b0;
        req_misalign = 1'b0;
        st_strb      = 4'b0000;
        st_data      = 32'h0;

        if (req_we_i) begin
            req_legal = (req_funct3_i == 3'b000) || (req_funct3_i == 3'b001) ||
                        (req_funct3_i == 3'b010);
        end else begin
            req_legal = (req_funct3_i == 3'b000) || (req_funct3_i == 3'b001) ||
                        (req_funct3_i == 3'b010) || (req_funct3_i == 3'b100) ||
                        (req_funct3_i == 3'b101);
        end

`ifdef MISALIGN_TRAP_EN
        // funct3[1:0] encodes the access size for every legal load and store.
        req_misalign = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                       ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
`else
        req_misalign = 1'b0;
`endif

        // Stores replicate the right-aligned data across lanes; strobes pick the lane.
        case (req_funct3_i[1:0])
            2'b00: begin
                st_strb = 4'b0001 << req_addr_i[1:0];
                st_data = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                st_strb = 4'b0011 << {req_addr_i[1], 1'b0};
                st_data = {2{req_wdata_i[15:0]}};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = req_wdata_i;
            end
        endcase
    end

    assign req_ok = req_legal && !req_misalign;

    // RAM interface is live only in the accepting cycle.
    assign mem_addr_o  = accept ? req_addr_i[ADDR_W+1:2] : '0;
    assign mem_read_o  = accept && !req_we_i && req_ok;
    assign mem_write_o = (accept && req_we_i && req_ok) ? st_strb : 4'b0000;
    assign mem_wdata_o = (accept && req_we_i && req_ok) ? st_data : 32'h0;

    // Load extraction from the registered RAM word using the latched offset/funct3.
    always_comb begin
        ld_byte  = 8'h0;
        ld_half  = 16'h0;
        ld_ext_d = 32'h0;

        case (off_q)
            2'd0:    ld_byte = mem_rdata_i[7:0];
            2'd1:    ld_byte = mem_rdata_i[15:8];
            2'd2:    ld_byte = mem_rdata_i[23:16];
            default: ld_byte = mem_rdata_i[31:24];
        endcase
        ld_half = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

        case (f3_q)
            3'b000:  ld_ext_d = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext_d = {24'h0, ld_byte};
            3'b001:  ld_ext_d = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext_d = {16'h0, ld_half};
            default: ld_ext_d = mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            off_q        <= 2'd0;
            f3_q         <= 3'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        off_q <= req_addr_i[1:0];
                        f3_q  <= req_funct3_i;
                        if (!req_ok) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= 32'h0;
                            resp_err_q   <= 1'b1;
                        end else if (req_we_i) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= 32'h0;
                            resp_err_q   <= 1'b0;
                        end else begin
                            state_q <= RD_DATA;
                        end
                    end
                end
                RD_DATA: begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= ld_ext_d;
                    resp_err_q   <= 1'b0;
                end
                RESP: begin
                    if (resp_ready_i) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= 32'h0;
                        resp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;

endmodule
